// File: rtl/layer_scheduler.sv
// Purpose: game-phase FSM, per-frame position shadows and per-pixel layer/ROM address generation.
// Latency: one pixel_tick from (h_cnt, v_cnt, valid) to layers/addresses, matching the 1-cycle ROMs.
// Backpressure: none; outputs advance only on pixel_tick and hold between ticks.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pixel_tick, valid, h_cnt/v_cnt VGA timing inputs
//   p1_x/p1_y/p2_x/p2_y           sprite top-left positions (latched at end of frame)
//   start_btn, p1_hit, p2_hit     one-cycle game-logic pulses
//   layers                        [3] title, [2] P1 sprite, [1] P2 sprite, [0] background
//   p1_addr, p2_addr, bg_addr     ROM read addresses
//   phase, score1, score2         game state
module layer_scheduler #(
  parameter int H_LAST      = 639,
  parameter int V_LAST      = 479,
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int SPR_AW      = 12,
  parameter int BG_W        = 320,
  parameter int BG_AW       = 17,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_FRAMES = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pixel_tick,
  input  logic              valid,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic [9:0]        p1_x,
  input  logic [9:0]        p1_y,
  input  logic [9:0]        p2_x,
  input  logic [9:0]        p2_y,
  input  logic              start_btn,
  input  logic              p1_hit,
  input  logic              p2_hit,
  output logic [3:0]        layers,
  output logic [SPR_AW-1:0] p1_addr,
  output logic [SPR_AW-1:0] p2_addr,
  output logic [BG_AW-1:0]  bg_addr,
  output logic [1:0]        phase,
  output logic [1:0]        score1,
  output logic [1:0]        score2
);

  typedef enum logic [1:0] {
    TITLE  = 2'd0,
    PLAY   = 2'd1,
    P1_WIN = 2'd2,
    P2_WIN = 2'd3
  } phase_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [1:0]    WIN2      = 2'(WIN_SCORE);
  localparam logic [10:0]   SPR_W11   = 11'(SPR_W);
  localparam logic [10:0]   SPR_H11   = 11'(SPR_H);

  phase_t          state, state_nxt;
  logic [1:0]      s1_nxt, s2_nxt, s1_inc, s2_inc;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [9:0]      sh_p1_x, sh_p1_y, sh_p2_x, sh_p2_y;
  logic            eof;

  assign eof   = pixel_tick && (h_cnt == 10'(H_LAST)) && (v_cnt == 10'(V_LAST));
  assign phase = state;

  // Saturating increments: a score never moves past WIN_SCORE.
  assign s1_inc = (score1 != WIN2) ? score1 + 2'd1 : score1;
  assign s2_inc = (score2 != WIN2) ? score2 + 2'd1 : score2;

  always_comb begin
    state_nxt = state;
    s1_nxt    = score1;
    s2_nxt    = score2;
    hold_nxt  = hold_cnt;
    case (state)
      TITLE: begin
        if (start_btn) begin
          state_nxt = PLAY;
          s1_nxt    = 2'd0;
          s2_nxt    = 2'd0;
        end
      end
      PLAY: begin
        if (p1_hit) s1_nxt = s1_inc;
        if (p2_hit) s2_nxt = s2_inc;
        // Decide on the updated scores so both final hits land and P1 takes the tie.
        if (s1_nxt == WIN2) begin
          state_nxt = P1_WIN;
          hold_nxt  = '0;
        end else if (s2_nxt == WIN2) begin
          state_nxt = P2_WIN;
          hold_nxt  = '0;
        end
      end
      default: begin
        if (eof) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = TITLE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TITLE;
      score1   <= 2'd0;
      score2   <= 2'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      score1   <= s1_nxt;
      score2   <= s2_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Positions are sampled once per frame so a mid-frame move cannot tear a sprite.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_p1_x <= '0;
      sh_p1_y <= '0;
      sh_p2_x <= '0;
      sh_p2_y <= '0;
    end else if (eof) begin
      sh_p1_x <= p1_x;
      sh_p1_y <= p1_y;
      sh_p2_x <= p2_x;
      sh_p2_y <= p2_y;
    end
  end

  // 11-bit differences: bit 10 is the borrow, so pixels left of/above the box never wrap in.
  logic [10:0]       dx1, dy1, dx2, dy2;
  logic              in1, in2;
  logic [SPR_AW-1:0] a1, a2;
  logic [BG_AW-1:0]  abg;

  assign dx1 = {1'b0, h_cnt} - {1'b0, sh_p1_x};
  assign dy1 = {1'b0, v_cnt} - {1'b0, sh_p1_y};
  assign dx2 = {1'b0, h_cnt} - {1'b0, sh_p2_x};
  assign dy2 = {1'b0, v_cnt} - {1'b0, sh_p2_y};

  assign in1 = !dx1[10] && (dx1 < SPR_W11) && !dy1[10] && (dy1 < SPR_H11);
  assign in2 = !dx2[10] && (dx2 < SPR_W11) && !dy2[10] && (dy2 < SPR_H11);

  // Operands are truncated before the multiply; modular arithmetic keeps the low bits exact.
  assign a1  = SPR_AW'(dy1) * SPR_AW'(SPR_W) + SPR_AW'(dx1);
  assign a2  = SPR_AW'(dy2) * SPR_AW'(SPR_W) + SPR_AW'(dx2);
  assign abg = BG_AW'(v_cnt[9:1]) * BG_AW'(BG_W) + BG_AW'(h_cnt[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      layers  <= 4'b0000;
      p1_addr <= '0;
      p2_addr <= '0;
      bg_addr <= '0;
    end else if (pixel_tick) begin
      if (!valid) begin
        layers  <= 4'b0000;
        p1_addr <= '0;
        p2_addr <= '0;
        bg_addr <= '0;
      end else begin
        layers[3] <= (state == TITLE);
        layers[2] <= in1 && ((state == PLAY) || (state == P1_WIN));
        layers[1] <= in2 && ((state == PLAY) || (state == P2_WIN));
        layers[0] <= 1'b1;
        p1_addr   <= in1 ? a1 : '0;
        p2_addr   <= in2 ? a2 : '0;
        bg_addr   <= abg;
      end
    end
  end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences the per-pixel layer compositor for the two-player VGA game.
- Tracks game phase (title / play / win) and frame timing.
- Latches player positions once per frame.
- Each pixel clock, generates the layer-select vector plus sprite and background ROM addresses, aligned to the synchronous ROM read latency.
- Sits between the VGA timing generator and game logic on the input side, and the sprite/background ROMs and pixel compositor on the output side.

Parameters:
- H_LAST, 639, last visible h_cnt.
- V_LAST, 479, last visible v_cnt.
- SPR_W, 64, sprite width in pixels.
- SPR_H, 64, sprite height in pixels.
- SPR_AW, 12, sprite ROM address width (holds SPR_W*SPR_H-1).
- BG_W, 320, background ROM line width; background is 2x upscaled.
- BG_AW, 17, background ROM address width.
- WIN_SCORE, 3, hits needed to win.
- HOLD_FRAMES, 120, frames the win screen is held.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pixel_tick  in  1  one-cycle pixel enable (25 MHz rate)
- valid  in  1  VGA visible-area flag
- h_cnt  in  10  horizontal pixel counter
- v_cnt  in  10  vertical pixel counter
- p1_x, p1_y, p2_x, p2_y  in  10 each  sprite top-left positions from game logic
- start_btn  in  1  debounced one-cycle start pulse
- p1_hit, p2_hit  in  1 each  one-cycle pulses: that player scored
- layers  out  4  compositor layer select: [3] title overlay, [2] P1 sprite, [1] P2 sprite, [0] background
- p1_addr, p2_addr  out  SPR_AW each  sprite ROM addresses
- bg_addr  out  BG_AW  background ROM address
- phase  out  2  0 = TITLE, 1 = PLAY, 2 = P1_WIN, 3 = P2_WIN
- score1, score2  out  2 each  current scores

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - phase=TITLE; score1=score2=0; frame hold counter=0.
  - layers=0; all addresses=0.
  - Shadow positions=0.
  - Reset mid-frame or mid-win-hold aborts immediately; no residual state.
- End-of-frame (eof): pixel_tick && h_cnt==H_LAST && v_cnt==V_LAST.
  - On eof, shadow registers load p1_x/p1_y/p2_x/p2_y.
  - Rendering uses shadows only, so position changes mid-frame never tear.
- FSM (evaluated every clk, not gated by pixel_tick):
  - TITLE -> PLAY on start_btn; scores cleared on entry.
  - PLAY:
    - p1_hit increments score1 (saturating at WIN_SCORE); p2_hit increments score2 likewise.
    - If score1 reaches WIN_SCORE -> P1_WIN; else if score2 reaches WIN_SCORE -> P2_WIN.
    - Simultaneous final hits on the same cycle: both scores update, P1_WIN wins the tie.
    - Transition takes effect the cycle after the hit.
  - P1_WIN / P2_WIN:
    - Hold counter cleared on entry, increments on each eof.
    - When it reaches HOLD_FRAMES -> TITLE.
    - Hits ignored.
  - start_btn ignored outside TITLE.
- Pixel pipeline: registered outputs, updated only on pixel_tick cycles; all outputs hold between ticks. Latency is one pixel_tick, matching the 1-cycle synchronous ROM, so ROM data and layers arrive together at the compositor.
  - valid=0: layers=0, all addresses=0.
  - In-box test for Pn: h_cnt-xn in [0,SPR_W-1] and v_cnt-yn in [0,SPR_H-1], computed unsigned 11-bit with an explicit borrow check. No wrap: h_cnt<xn is outside.
  - layers[2]: inside P1 box and phase is PLAY or P1_WIN.
  - layers[1]: inside P2 box and phase is PLAY or P2_WIN.
  - layers[3]: phase==TITLE.
  - layers[0]: 1 whenever valid.
  - Multiple bits may be set; priority is resolved downstream by the compositor.
- Address generation:
  - pn_addr = (v_cnt-yn)*SPR_W + (h_cnt-xn), truncated to SPR_AW, when inside the box; 0 otherwise.
  - bg_addr = (v_cnt>>1)*BG_W + (h_cnt>>1), truncated to BG_AW.
- Positions with x > H_LAST-SPR_W+1 produce a clipped sprite (right columns never drawn); no error.

Test Plan:
- Reset checks:
  - rst held 2 cycles mid-PLAY with score1=2 -> phase=0, scores 0, layers=0, addresses 0.
  - Reset outputs are valid on the cycle after rst deasserts.
- Sprite box: TITLE -> start_btn -> PLAY; p1_x=100, p1_y=50.
  - Scan pixel (100,50) -> one tick later layers=4'b0101, p1_addr=0.
  - Pixel (163,113) -> p1_addr=4095.
  - Pixel (99,50) and (164,50) -> layers[2]=0.
- Background address: pixel (639,479) with valid=1 -> bg_addr=239*320+319=76799.
  - valid=0 -> layers=0 and all addresses 0.
- Tearing: change p1_x from 100 to 200 mid-frame.
  - Pixel (150,60) still shows layers[2]=1 until after eof.
  - Next frame, (150,60) has layers[2]=0.
- Scoring and win hold:
  - Three p2_hit pulses -> phase=3 on the cycle after the third, score2=3.
  - Further hits do not change scores.
  - After 120 eof events -> phase=0.
  - layers[2] is 0 during P2_WIN.
- Tie: score1=score2=2, then p1_hit and p2_hit on the same cycle -> phase=2, score1=score2=3.
  - start_btn in PLAY -> no effect.
